proc_ctrl_fsm: RTL and testbench

- Instruction-sequencing controller for the simple processor.
- Owns the PC: drives clear, increment and jump-load. Loads the IR and decodes each instruction.
- Steps data memory, register file and ALU through one state per micro-step.
- Moore machine: every control output is a pure function of the registered state and the held IR.

---
 rtl/proc_pkg.sv | 50 +++++
 rtl/proc_ctrl_fsm.sv | 138 +++++++++++++
 tb/tb_proc_ctrl_fsm.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared types for the processor control path.
// States, opcodes, ALU selects and decode helper.
package proc_pkg;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_STORE  = 4'd4,
    S_LOAD_A = 4'd5,
    S_LOAD_B = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9,
    S_JUMP   = 4'd10
  } ctrl_state_t;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5,
    OP_JMP   = 4'd6
  } opcode_t;

  localparam logic [1:0] ALU_PASS = 2'd0;
  localparam logic [1:0] ALU_ADD  = 2'd1;
  localparam logic [1:0] ALU_SUB  = 2'd2;

  // Execute state entered from Decode.
  // Opcodes 7..15 fall back to NoOp.
  function automatic ctrl_state_t
    op_to_state(input logic [3:0] op);
    ctrl_state_t s;
    case (op)
      OP_STORE: s = S_STORE;
      OP_LOAD:  s = S_LOAD_A;
      OP_ADD:   s = S_ADD;
      OP_SUB:   s = S_SUB;
      OP_HALT:  s = S_HALT;
      OP_JMP:   s = S_JUMP;
      default:  s = S_NOOP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/proc_ctrl_fsm.sv
// Instruction sequencing controller.
// Moore FSM: outputs depend on state and held IR.
module proc_ctrl_fsm
  import proc_pkg::*;
#(
  parameter int PC_W  = 7,
  parameter int IR_W  = 16,
  parameter int D_AW  = 8,
  parameter int RF_AW = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [IR_W-1:0]  IR,
  output logic             PC_up,
  output logic             PC_clr,
  output logic             PC_ld,
  output logic [PC_W-1:0]  PC_jaddr,
  output logic             IR_ld,
  output logic [D_AW-1:0]  D_addr,
  output logic             D_wr,
  output logic             RF_s,
  output logic [RF_AW-1:0] RF_W_addr,
  output logic             RF_W_en,
  output logic [RF_AW-1:0] RF_Ra_addr,
  output logic [RF_AW-1:0] RF_Rb_addr,
  output logic [1:0]       ALU_s0,
  output logic [3:0]       State
);

  ctrl_state_t r_state;
  ctrl_state_t w_next;

  logic [3:0]       w_op;
  logic [RF_AW-1:0] w_d;
  logic [RF_AW-1:0] w_b;
  logic [RF_AW-1:0] w_c;
  logic [D_AW-1:0]  w_addr;
  logic [PC_W-1:0]  w_jaddr;

  assign w_op    = IR[15:12];
  assign w_d     = IR[11:8];
  assign w_b     = IR[7:4];
  assign w_c     = IR[3:0];
  assign w_addr  = IR[7:0];
  assign w_jaddr = IR[6:0];

  assign State = r_state;

  // Next state from current state and opcode.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_INIT:   w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = op_to_state(w_op);
      S_LOAD_A: w_next = S_LOAD_B;
      S_NOOP,
      S_STORE,
      S_LOAD_B,
      S_ADD,
      S_SUB,
      S_JUMP:   w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_INIT;
    endcase
  end

  // State register; reset aborts any step.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  // Control outputs decoded from state and IR.
  always_comb begin
    PC_up      = 1'b0;
    PC_clr     = 1'b0;
    PC_ld      = 1'b0;
    PC_jaddr   = '0;
    IR_ld      = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s0     = ALU_PASS;
    unique case (r_state)
      S_INIT: begin
        PC_clr = 1'b1;
      end
      S_FETCH: begin
        IR_ld = 1'b1;
        PC_up = 1'b1;
      end
      S_STORE: begin
        D_addr     = w_addr;
        RF_Ra_addr = w_d;
        D_wr       = 1'b1;
      end
      S_LOAD_A: begin
        D_addr    = w_addr;
        RF_s      = 1'b1;
        RF_W_addr = w_d;
      end
      S_LOAD_B: begin
        D_addr    = w_addr;
        RF_s      = 1'b1;
        RF_W_addr = w_d;
        RF_W_en   = 1'b1;
      end
      S_ADD: begin
        RF_Ra_addr = w_b;
        RF_Rb_addr = w_c;
        ALU_s0     = ALU_ADD;
        RF_W_addr  = w_d;
        RF_W_en    = 1'b1;
      end
      S_SUB: begin
        RF_Ra_addr = w_b;
        RF_Rb_addr = w_c;
        ALU_s0     = ALU_SUB;
        RF_W_addr  = w_d;
        RF_W_en    = 1'b1;
      end
      S_JUMP: begin
        PC_ld    = 1'b1;
        PC_jaddr = w_jaddr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Bench for proc_ctrl_fsm: program memory, PC/IR
// environment and per-cycle reference model.
module tb_proc_ctrl_fsm;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [15:0] IR;
  logic        PC_up, PC_clr, PC_ld;
  logic [6:0]  PC_jaddr;
  logic        IR_ld;
  logic [7:0]  D_addr;
  logic        D_wr, RF_s;
  logic [3:0]  RF_W_addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_addr, RF_Rb_addr;
  logic [1:0]  ALU_s0;
  logic [3:0]  State;

  typedef struct packed {
    logic       up;
    logic       clr;
    logic       ld;
    logic [6:0] ja;
    logic       irld;
    logic [7:0] da;
    logic       dwr;
    logic       rfs;
    logic [3:0] wa;
    logic       wen;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [1:0] alu;
    logic [3:0] st;
  } out_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem [128];
  logic [6:0]  pc_env = '0;
  logic [15:0] ir_env = '0;
  logic [6:0]  exp_pc;
  out_t        obs;

  assign IR = ir_env;
  assign obs = {PC_up, PC_clr, PC_ld, PC_jaddr, IR_ld,
                D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
                RF_Ra_addr, RF_Rb_addr, ALU_s0, State};

  proc_ctrl_fsm dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .IR         (IR),
    .PC_up      (PC_up),
    .PC_clr     (PC_clr),
    .PC_ld      (PC_ld),
    .PC_jaddr   (PC_jaddr),
    .IR_ld      (IR_ld),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_addr  (RF_W_addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .ALU_s0     (ALU_s0),
    .State      (State)
  );

  always #5 Clk = ~Clk;

  // PC and IR registers steered by the controller
  always @(posedge Clk) begin
    if (PC_clr)     pc_env <= '0;
    else if (PC_ld) pc_env <= PC_jaddr;
    else if (PC_up) pc_env <= pc_env + 7'd1;
    if (IR_ld) ir_env <= mem[pc_env];
  end

  // Expected outputs for step k of instruction ins
  // (k = -1 is the Init/reset cycle).
  function automatic out_t model(input int k,
                                 input logic [15:0] ins);
    out_t e;
    int   op;
    e  = '0;
    op = int'(ins[15:12]);
    if (k < 0) begin
      e.clr = 1'b1;
    end else if (k == 0) begin
      e.up = 1'b1; e.irld = 1'b1; e.st = 4'd1;
    end else if (k == 1) begin
      e.st = 4'd2;
    end else if (k == 3) begin
      e.st = 4'd6; e.da = ins[7:0]; e.rfs = 1'b1;
      e.wa = ins[11:8]; e.wen = 1'b1;
    end else begin
      case (op)
        1: begin
          e.st = 4'd4; e.da = ins[7:0];
          e.ra = ins[11:8]; e.dwr = 1'b1;
        end
        2: begin
          e.st = 4'd5; e.da = ins[7:0];
          e.rfs = 1'b1; e.wa = ins[11:8];
        end
        3, 4: begin
          e.st  = (op == 3) ? 4'd7 : 4'd8;
          e.alu = (op == 3) ? 2'd1 : 2'd2;
          e.ra = ins[7:4]; e.rb = ins[3:0];
          e.wa = ins[11:8]; e.wen = 1'b1;
        end
        5: e.st = 4'd9;
        6: begin
          e.st = 4'd10; e.ld = 1'b1; e.ja = ins[6:0];
        end
        default: e.st = 4'd3;
      endcase
    end
    return e;
  endfunction

  task automatic check(input string tag,
                       input logic [39:0] o,
                       input logic [39:0] x);
    n_tests++;
    assert (o === x) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, x);
    end
  endtask

  // Compare all outputs plus the cross-signal rules.
  task automatic step(input string tag, input int k,
                      input logic [15:0] ins);
    logic [2:0] pcc;
    check(tag, obs, model(k, ins));
    pcc = {PC_clr, PC_up, PC_ld};
    check({tag, "_pc1hot"}, {37'd0, pcc},
          {37'd0, (pcc == 3'b100 || pcc == 3'b010 ||
                   pcc == 3'b001) ? pcc : 3'b000});
    check({tag, "_wrx"}, {39'd0, D_wr & RF_W_en}, 40'd0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    #1 step("rst_async", -1, 16'h0);
    repeat (2) begin
      @(negedge Clk);
      step("rst_hold", -1, 16'h0);
    end
    Reset_n = 1'b1;
    #1 step("init", -1, 16'h0);
    @(negedge Clk);
    exp_pc = '0;
  endtask

  // Called at the sample point of a Fetch cycle.
  task automatic run_instr(input string tag);
    logic [15:0] ins;
    int          n;
    ins = mem[exp_pc];
    check({tag, "_pc"}, {33'd0, pc_env}, {33'd0, exp_pc});
    n = (ins[15:12] == 4'd2) ? 4 : 3;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge Clk);
      step(tag, k, ins);
    end
    exp_pc = (ins[15:12] == 4'd6) ? ins[6:0]
                                  : exp_pc + 7'd1;
    @(negedge Clk);
  endtask

  initial begin
    logic [15:0] r;
    logic [3:0]  op;

    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    mem[0] = 16'h2A05;
    mem[1] = 16'h3123;
    mem[2] = 16'h4123;
    mem[3] = 16'h1C80;
    mem[4] = 16'h607F;

    // Directed program, ends with JMP 127 and wrap
    do_reset();
    for (int i = 0; i < 7; i++) run_instr("dir");

    // 128+ NOOP/illegal fetches: PC wraps 127 -> 0
    for (int i = 0; i < 128; i++) begin
      r  = 16'($urandom);
      op = (r[15:12] < 4'd7) ? 4'd0 : r[15:12];
      mem[i] = {op, r[11:0]};
    end
    do_reset();
    for (int i = 0; i < 128; i++) run_instr("nop");
    check("wrap", {33'd0, pc_env}, 40'd0);
    for (int i = 0; i < 3; i++) run_instr("nop2");

    // Random mix of every non-HALT opcode
    for (int i = 0; i < 128; i++) begin
      r  = 16'($urandom);
      op = (r[15:12] == 4'd5) ? 4'd3 : r[15:12];
      mem[i] = {op, r[11:0]};
    end
    do_reset();
    for (int i = 0; i < 200; i++) run_instr("rnd");

    // HALT holds until reset
    mem[exp_pc] = 16'h5000;
    check("h_pc", {33'd0, pc_env}, {33'd0, exp_pc});
    step("h_fetch", 0, 16'h5000);
    @(negedge Clk);
    step("h_dec", 1, 16'h5000);
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      step("halt", 2, 16'h5000);
    end

    // Reset during Load_A: no Load_B write follows
    mem[0] = 16'h2A05;
    do_reset();
    step("la_fetch", 0, 16'h2A05);
    @(negedge Clk);
    step("la_dec", 1, 16'h2A05);
    @(negedge Clk);
    step("la_a", 2, 16'h2A05);
    #2 Reset_n = 1'b0;
    #1 step("la_abort", -1, 16'h0);
    check("la_wen", {39'd0, RF_W_en}, 40'd0);
    @(negedge Clk);
    step("la_held", -1, 16'h0);
    Reset_n = 1'b1;
    @(negedge Clk);
    exp_pc = '0;
    run_instr("post");

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
